// File: rtl/ccg_pkg.sv
// Shared constants and A/B evaluation helpers for the ccg pipelined evaluator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ccg_pkg;

  localparam logic [15:0] DEF_OUT_SEL = 16'h9780;
  localparam logic [15:0] DEF_POLY    = 16'h8016;
  localparam int          DEF_IA0     = 3;
  localparam int          DEF_IA1     = 9;
  localparam int          DEF_IA2     = 5;
  localparam int          DEF_IA3     = 6;

  // Function A: XOR of two selected bits, OR'ed with the NOR of two others.
  function automatic logic ccg_eval_a(input logic [31:0] xv,
                                      input logic [4:0]  i0,
                                      input logic [4:0]  i1,
                                      input logic [4:0]  i2,
                                      input logic [4:0]  i3);
    return (xv[i0] ^ xv[i1]) | ~(xv[i2] | xv[i3]);
  endfunction

  // Function B: parity of the masked input vector.
  function automatic logic ccg_eval_b(input logic [31:0] xv,
                                      input logic [31:0] mask);
    return ^(xv & mask);
  endfunction

endpackage

// File: rtl/ccg_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data register.
// Latency: 1 cycle from load to valid.
// Backpressure: loads only when the parent asserts load (slot empty or draining).
module ccg_pipe_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Capture upstream content when allowed; data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/ccg_pipe_eval.sv
// Evaluates functions A/B on x, spreads them over f per OUT_SEL, optional MISR (CCG_MISR_EN).
// Latency: DEPTH cycles from input transfer to out_valid; 1 vector/cycle throughput.
// Backpressure: in_ready = some stage empty or out_ready; full pipe holds f stable on stall.
module ccg_pipe_eval
  import ccg_pkg::*;
#(
  parameter int                N_IN    = 12,
  parameter int                N_OUT   = 16,
  parameter int                DEPTH   = 2,
  parameter int                IA0     = DEF_IA0,
  parameter int                IA1     = DEF_IA1,
  parameter int                IA2     = DEF_IA2,
  parameter int                IA3     = DEF_IA3,
  parameter logic [N_IN-1:0]   MASK_B  = '1,
  parameter logic [N_OUT-1:0]  OUT_SEL = N_OUT'(DEF_OUT_SEL),
  parameter logic [N_OUT-1:0]  POLY    = N_OUT'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CCG_MISR_EN
  input  logic             sig_clr,
  output logic [N_OUT-1:0] sig,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f
);

  logic [31:0]      x_ext;
  logic [31:0]      mask_ext;
  logic             a_bit;
  logic             b_bit;
  logic [N_OUT-1:0] f_new;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;
  logic [N_OUT-1:0] dat [DEPTH];

  assign x_ext    = 32'(x);
  assign mask_ext = 32'(MASK_B);

  // Evaluate A and B, then route each output bit to its selected function.
  always_comb begin
    a_bit = ccg_eval_a(x_ext, IA0[4:0], IA1[4:0], IA2[4:0], IA3[4:0]);
    b_bit = ccg_eval_b(x_ext, mask_ext);
    f_new = (OUT_SEL & {N_OUT{b_bit}}) | (~OUT_SEL & {N_OUT{a_bit}});
  end

  // A stage may load if any stage at or after it is empty, or the sink takes data.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      rdy_acc = rdy_acc | ~vld[s];
      rdy[s]  = rdy_acc;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic             up_v;
    logic [N_OUT-1:0] up_d;
    if (s == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = f_new;
    end else begin : g_body
      assign up_v = vld[s-1];
      assign up_d = dat[s-1];
    end
    ccg_pipe_stage #(.W(N_OUT)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[s]),
      .in_valid (up_v),
      .in_data  (up_d),
      .valid    (vld[s]),
      .data     (dat[s])
    );
  end

  // Masking with rst guarantees no handshake completes during the reset cycle.
  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = vld[DEPTH-1] & ~rst;
  assign f         = dat[DEPTH-1];

`ifdef CCG_MISR_EN
  // Signature register: clear wins over an update; folds f in on each output transfer.
  always_ff @(posedge clk) begin
    if (rst || sig_clr) begin
      sig <= '0;
    end else if (out_valid && out_ready) begin
      sig <= {sig[N_OUT-2:0], 1'b0} ^ (sig[N_OUT-1] ? POLY : '0) ^ f;
    end
  end
`endif

endmodule
